// File: rtl/serial_add_ctrl_pkg.sv
// Shared FSM state encodings for the bit-serial adder controller.
// Encodings match the legacy ST_* values so existing decoders keep working.
package serial_add_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell shared by the serial datapath.
module full_add (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_add cell sequenced LSB first over WIDTH bits.
// Optional signed-overflow output is enabled by defining OVERFLOW_FLAG_EN.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef OVERFLOW_FLAG_EN
   ,output logic            ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [CNT_W-1:0] cnt;
   logic             carry_ff;
   logic             sum_bit;
   logic             cout_bit;
   logic [WIDTH:0]   s_cat;
   logic [WIDTH-1:0] s_next;

   full_add u_full_add (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_ff),
      .sum  (sum_bit),
      .cout (cout_bit)
   );

   // Concatenate-then-slice keeps the right shift legal when WIDTH is 1.
   assign s_cat  = {sum_bit, s_sr};
   assign s_next = s_cat[WIDTH:1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         s_sr     <= '0;
         cnt      <= '0;
         carry_ff <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         ovf      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  carry_ff <= cin;
                  cnt      <= '0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               s_sr     <= s_next;
               carry_ff <= cout_bit;
               a_sr     <= a_sr >> 1;
               b_sr     <= b_sr >> 1;
               cnt      <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  sum   <= s_next;
                  cout  <= cout_bit;
`ifdef OVERFLOW_FLAG_EN
                  // carry_ff holds the carry into the MSB on this final step.
                  ovf   <= carry_ff ^ cout_bit;
`endif
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state == ST_SHIFT);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
// Define OVERFLOW_FLAG_EN for both bench and RTL to exercise the ovf port.
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef OVERFLOW_FLAG_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef OVERFLOW_FLAG_EN
      ,.ovf  (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer addition and two's-complement overflow rule.
   task automatic expect_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input logic ec);
      logic [W:0] r;
      r = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
      check({tag, "_sum"},  32'(sum),  32'(r[W-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(r[W]));
`ifdef OVERFLOW_FLAG_EN
      check({tag, "_ovf"}, 32'(ovf),
            32'((ea[W-1] == eb[W-1]) && (r[W-1] != ea[W-1])));
`endif
   endtask

   // Issue one request, then check busy for W cycles, the done pulse, result, and return to idle.
   task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc);
      a = va; b = vb; cin = vc; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         tick();
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      expect_result(tag, va, vb, vc);
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      expect_result({tag, "_held"}, va, vb, vc);
   endtask

   initial begin
      int done_cyc[$];
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_cout", 32'(cout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
      check("rst_ovf",  32'(ovf),  32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      run_op("t1", 8'hFF, 8'h01, 1'b0);
      run_op("t2", 8'h7F, 8'h01, 1'b0);
      run_op("t3", 8'h00, 8'h00, 1'b1);

      // Second start during SHIFT must not relatch operands or produce a second done.
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a = 8'hAA; b = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) done_cyc.push_back(i);
         if (done) expect_result("t4", 8'h0F, 8'h01, 1'b0);
         tick();
      end
      check("t4_done_count", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() == 1) check("t4_done_cyc", 32'(done_cyc[0]), 32'd6);
      done_cyc.delete();

      // Asynchronous abort mid-operation.
      a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_sum",  32'(sum),  32'd0);
      check("t5_cout", 32'(cout), 32'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) done_cyc.push_back(i);
      end
      check("t5_quiet", 32'(done_cyc.size()), 32'd0);
      done_cyc.delete();
      run_op("t5b", 8'h12, 8'h34, 1'b0);

      // Back-to-back operation with start held high.
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         check("t6_noX", 32'($isunknown({busy, done, sum, cout})), 32'd0);
         if (done) begin
            done_cyc.push_back(i);
            expect_result("t6", 8'h80, 8'h80, 1'b0);
         end
      end
      start = 1'b0;
      check("t6_done_count", 32'(done_cyc.size()), 32'd4);
      for (int i = 1; i < done_cyc.size(); i++)
         check("t6_period", 32'(done_cyc[i] - done_cyc[i-1]), 32'd10);
      done_cyc.delete();
      tick(); tick(); tick();

      // Randomized operands against the arithmetic model.
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         run_op("rand", ra, rb, rc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
